// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: next-PC selector codes,
// IF state encoding and the default bubble instruction.
package instruction_fetch_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_REG = 2'b10;
   localparam logic [1:0] PCSRC_JMP = 2'b11;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } if_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, and a cycle
// with nothing to load inserts a bubble.
module if_id_reg
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        flush,
   input  logic        load,
   input  logic [31:0] inst_in,
   input  logic [31:0] pc4_in,
   output logic        valid,
   output logic [31:0] inst,
   output logic [31:0] pc4
);

   logic        valid_q, valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;

   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc4_d   = pc4_q;
      if (flush) begin
         valid_d = 1'b0;
         inst_d  = NOP_INST;
      end else if (!hold) begin
         if (load) begin
            valid_d = 1'b1;
            inst_d  = inst_in;
            pc4_d   = pc4_in;
         end else begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         inst_q  <= NOP_INST;
         pc4_q   <= RESET_PC + 32'd4;
      end else begin
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc4_q   <= pc4_d;
      end
   end

   assign valid = valid_q;
   assign inst  = inst_q;
   assign pc4   = pc4_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, next-PC select, req/ready fetch FSM with skid and kill, IF/ID.
// Define IF_PERF_EN to add the perf_fetched/perf_squashed counters.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] rpc,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] id_pc4,
   output logic [31:0] id_inst,
   output logic        id_valid
`ifdef IF_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_squashed
`endif
);

   if_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic [31:0] kill_addr_q, kill_addr_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;
   logic        req_en_q, req_en_d;

   logic        redirect;
   logic        resp;
   logic        squash;
   logic [31:0] pc_plus4;
   logic [31:0] target;
   logic        ifid_load;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc4;

   assign pc_plus4 = pc_q + 32'd4;
   assign redirect = (pcsource != PCSRC_SEQ) && id_valid && !id_stall;
   assign req_en_d = 1'b1;

   // req stays low for the first cycle out of reset
   assign imem_req  = req_en_q && (state_q == FETCH);
   // a killed request keeps its original address until the memory accepts it
   assign imem_addr = kill_q ? kill_addr_q : pc_q;
   assign resp      = imem_req && imem_ready;

   always_comb begin
      target = pc_plus4;
      case (pcsource)
         PCSRC_BR:  target = word_align(bpc);
         PCSRC_REG: target = word_align(rpc);
         PCSRC_JMP: target = word_align(jpc);
         default:   target = pc_plus4;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_d      = kill_q;
      kill_addr_d = kill_addr_q;
      skid_inst_d = skid_inst_q;
      skid_pc4_d  = skid_pc4_q;
      ifid_load   = 1'b0;
      ifid_inst   = imem_rdata;
      ifid_pc4    = pc_plus4;
      squash      = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (redirect) begin
               pc_d = target;
               if (resp) begin
                  squash = 1'b1;
               end else if (imem_req && !kill_q) begin
                  kill_d      = 1'b1;
                  kill_addr_d = pc_q;
               end
            end else if (resp) begin
               if (kill_q) begin
                  kill_d = 1'b0;
                  squash = 1'b1;
               end else if (id_stall) begin
                  skid_inst_d = imem_rdata;
                  skid_pc4_d  = pc_plus4;
                  pc_d        = pc_plus4;
                  state_d     = HOLD;
               end else begin
                  ifid_load = 1'b1;
                  pc_d      = pc_plus4;
               end
            end
         end
         HOLD: begin
            ifid_inst = skid_inst_q;
            ifid_pc4  = skid_pc4_q;
            // a redirect from the instruction ahead makes the skid entry wrong-path
            if (redirect) begin
               pc_d    = target;
               state_d = FETCH;
               squash  = 1'b1;
            end else if (!id_stall) begin
               ifid_load = 1'b1;
               state_d   = FETCH;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         state_q     <= FETCH;
         pc_q        <= word_align(RESET_PC);
         kill_q      <= 1'b0;
         kill_addr_q <= '0;
         skid_inst_q <= NOP_INST;
         skid_pc4_q  <= '0;
         req_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_q      <= kill_d;
         kill_addr_q <= kill_addr_d;
         skid_inst_q <= skid_inst_d;
         skid_pc4_q  <= skid_pc4_d;
         req_en_q    <= req_en_d;
      end
   end

   if_id_reg #(
      .RESET_PC (RESET_PC),
      .NOP_INST (NOP_INST)
   ) u_if_id (
      .clk     (clk),
      .rst     (clrn),
      .hold    (id_stall),
      .flush   (redirect),
      .load    (ifid_load),
      .inst_in (ifid_inst),
      .pc4_in  (ifid_pc4),
      .valid   (id_valid),
      .inst    (id_inst),
      .pc4     (id_pc4)
   );

`ifdef IF_PERF_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] squashed_q, squashed_d;

   always_comb begin
      fetched_d  = fetched_q;
      squashed_d = squashed_q;
      if (ifid_load && (fetched_q != '1)) begin
         fetched_d = fetched_q + 32'd1;
      end
      if (squash && (squashed_q != '1)) begin
         squashed_d = squashed_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         fetched_q  <= '0;
         squashed_q <= '0;
      end else begin
         fetched_q  <= fetched_d;
         squashed_q <= squashed_d;
      end
   end

   assign perf_fetched  = fetched_q;
   assign perf_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: random memory latency, decode stalls
// and redirects checked against a program-order reference model.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        clrn = 1'b1;
   logic [1:0]  pcsource = 2'b00;
   logic [31:0] bpc = '0;
   logic [31:0] jpc = '0;
   logic [31:0] rpc = '0;
   logic        id_stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] id_pc4;
   logic [31:0] id_inst;
   logic        id_valid;
`ifdef IF_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_squashed;
`endif

   instruction_fetch #(
      .RESET_PC (RST_PC),
      .NOP_INST (NOP)
   ) dut (
      .clk        (clk),
      .clrn       (clrn),
      .pcsource   (pcsource),
      .bpc        (bpc),
      .jpc        (jpc),
      .rpc        (rpc),
      .id_stall   (id_stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .id_pc4     (id_pc4),
      .id_inst    (id_inst),
      .id_valid   (id_valid)
`ifdef IF_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_squashed (perf_squashed)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // stimulus modes: -1 = random, otherwise forced value
   int          wait_fix  = 0;
   int          stall_fix = 0;
   int          pcs_fix   = 0;
   logic [31:0] tgt_fix   = '0;

   // reference model: program-order address of the next instruction decode should see
   logic [31:0] exp_addr;
   bit          fresh;
   bit          prev_redirect;
   bit          prev_stall_nop;
   int          idle;
   bit          pend;
   int          cnt;
   logic [31:0] pend_addr;
   bit          doomed;
   int unsigned exp_fetched;
   int unsigned exp_squashed;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      exp_addr       = RST_PC;
      fresh          = 1'b1;
      prev_redirect  = 1'b0;
      prev_stall_nop = 1'b0;
      idle           = 0;
      pend           = 1'b0;
      cnt            = 0;
      pend_addr      = '0;
      doomed         = 1'b0;
      exp_fetched    = 0;
      exp_squashed   = 0;
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_req",   32'(imem_req), 32'd0);
      check_eq("rst_valid", 32'(id_valid), 32'd0);
      check_eq("rst_inst",  id_inst, NOP);
      check_eq("rst_pc4",   id_pc4, RST_PC + 32'd4);
`ifdef IF_PERF_EN
      check_eq("rst_perf_fetched",  perf_fetched, 32'd0);
      check_eq("rst_perf_squashed", perf_squashed, 32'd0);
`endif
   endtask

   // one clock cycle: sample outputs, drive decode/memory inputs, update the model
   task automatic step();
      bit          consume;
      bit          redir;
      bit          rdy;
      logic [31:0] tgt;
      @(negedge clk);
      check_eq("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (pend) begin
         check_eq("req_held",  32'(imem_req), 32'd1);
         check_eq("addr_held", imem_addr, pend_addr);
      end

      if (id_valid && fresh) exp_fetched++;
`ifdef IF_PERF_EN
      check_eq("perf_fetched",  perf_fetched, 32'(exp_fetched));
      check_eq("perf_squashed", perf_squashed, 32'(exp_squashed));
`endif

      if (!id_valid) begin
         pcsource = 2'($urandom_range(0, 3));
         bpc = $urandom; jpc = $urandom; rpc = $urandom;
      end else if (fresh) begin
         if (pcs_fix >= 0) begin
            pcsource = 2'(pcs_fix);
            bpc = tgt_fix; jpc = tgt_fix; rpc = tgt_fix;
         end else begin
            pcsource = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            bpc = $urandom; jpc = $urandom; rpc = $urandom;
         end
      end
      id_stall = (stall_fix < 0) ? ($urandom_range(0, 9) < 3) : (stall_fix != 0);

      rdy = 1'b0;
      if (imem_req) begin
         if (!pend) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            if (wait_fix >= 0) cnt = wait_fix;
            else cnt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
         end
         if (cnt == 0) begin
            rdy  = 1'b1;
            pend = 1'b0;
         end else begin
            cnt--;
         end
      end
      imem_ready = rdy;
      imem_rdata = rdy ? mem_word(pend_addr) : $urandom;

      if (id_valid) begin
         check_eq("id_pc4",  id_pc4, exp_addr + 32'd4);
         check_eq("id_inst", id_inst, mem_word(exp_addr));
      end else begin
         check_eq("nop_inst", id_inst, NOP);
      end
      if (prev_redirect)  check_eq("nop_after_redirect", 32'(id_valid), 32'd0);
      if (prev_stall_nop) check_eq("stall_holds_nop",    32'(id_valid), 32'd0);

      consume = id_valid && !id_stall;
      redir   = consume && (pcsource != 2'b00);
      case (pcsource)
         2'b01:   tgt = bpc;
         2'b10:   tgt = rpc;
         default: tgt = jpc;
      endcase

      if (rdy && doomed) begin
         exp_squashed++;
         doomed = 1'b0;
      end
      if (redir) begin
         if (rdy) exp_squashed++;
         else if (imem_req) doomed = 1'b1;
         else exp_squashed++;
      end

      if (consume) begin
         exp_addr = redir ? (tgt & 32'hFFFF_FFFC) : exp_addr + 32'd4;
         idle = 0;
      end else begin
         idle++;
         if (idle == 200) check_eq("progress", 32'(idle), 32'd0);
      end
      prev_redirect  = redir;
      prev_stall_nop = !id_valid && id_stall;
      fresh          = !(id_valid && id_stall);
   endtask

   task automatic redirect_to(input logic [1:0] pcs, input logic [31:0] t);
      pcs_fix = int'(pcs);
      tgt_fix = t;
      step();
      pcs_fix = 0;
      check_eq("redir_src_valid", 32'(id_valid), 32'd1);
   endtask

   task automatic async_reset();
      #2;
      clrn = 1'b1;
      imem_ready = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      repeat (2) @(negedge clk);
      clrn = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs();
      clrn = 1'b0;

      // zero-wait sequential stream
      for (int k = 0; k < 10; k++) begin
         step();
         check_eq("seq_addr", imem_addr, 32'(4 * k));
         if (k == 0) check_eq("seq_first_valid", 32'(id_valid), 32'd0);
         else begin
            check_eq("seq_valid", 32'(id_valid), 32'd1);
            check_eq("seq_pc4",   id_pc4, 32'(4 * k));
         end
      end

      // branch with the response ready in the same cycle
      redirect_to(PCSRC_BR, 32'h0000_0100);
      step();
      check_eq("br_bubble", 32'(id_valid), 32'd0);
      check_eq("br_addr",   imem_addr, 32'h0000_0100);
      step();
      check_eq("br_valid",  32'(id_valid), 32'd1);
      check_eq("br_pc4",    id_pc4, 32'h0000_0104);

      // stall while the response at 0x10 arrives
      redirect_to(PCSRC_JMP, 32'h0000_0010);
      stall_fix = 1;
      step();
      check_eq("stall_addr", imem_addr, 32'h0000_0010);
      check_eq("stall_req",  32'(imem_req), 32'd1);
      step();
      check_eq("hold_req1",  32'(imem_req), 32'd0);
      step();
      check_eq("hold_req2",  32'(imem_req), 32'd0);
      stall_fix = 0;
      step();
      check_eq("hold_req3",  32'(imem_req), 32'd0);
      step();
      check_eq("release_valid", 32'(id_valid), 32'd1);
      check_eq("release_pc4",   id_pc4, 32'h0000_0014);
      check_eq("release_addr",  imem_addr, 32'h0000_0014);

      // redirect while a slow request is outstanding
      redirect_to(PCSRC_JMP, 32'h0000_001C);
      step();
      wait_fix = 4;
      pcs_fix  = 3;
      tgt_fix  = 32'h0000_0200;
      step();
      pcs_fix  = 0;
      check_eq("kill_src_pc4", id_pc4, 32'h0000_0020);
      check_eq("kill_addr0",   imem_addr, 32'h0000_0020);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("kill_addr",  imem_addr, 32'h0000_0020);
         check_eq("kill_valid", 32'(id_valid), 32'd0);
      end
      wait_fix = 0;
      step();
      check_eq("kill_target", imem_addr, 32'h0000_0200);
      check_eq("kill_bubble", 32'(id_valid), 32'd0);

      // wrap at the top of the address space
      redirect_to(PCSRC_JMP, 32'hFFFF_FFF8);
      step();
      step();
      check_eq("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      step();
      check_eq("wrap_addr", imem_addr, 32'h0000_0000);
      check_eq("wrap_pc4",  id_pc4, 32'h0000_0000);

      // misaligned register target
      redirect_to(PCSRC_REG, 32'h0000_0303);
      step();
      check_eq("align_target", imem_addr, 32'h0000_0300);

      // reset in the middle of a 3-cycle wait
      wait_fix = 3;
      step();
      check_eq("wait_req", 32'(imem_req), 32'd1);
      async_reset();
      wait_fix = 0;
      step();
      check_eq("post_rst_req",  32'(imem_req), 32'd1);
      check_eq("post_rst_addr", imem_addr, RST_PC);

      // randomized traffic with one mid-run reset
      wait_fix  = -1;
      stall_fix = -1;
      pcs_fix   = -1;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (i == 1500) async_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage and IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC and issues requests to instruction memory over a variable-latency req/ready handshake.
- Selects the next PC from decode's pcsource/bpc/jpc and presents pc4/inst/valid to decode.
- Handles decode stalls and squashes wrong-path fetches on redirect; there is no delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, value driven on id_inst when the slot is invalid or squashed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  reset; asynchronous, active-high (1 = reset).
- pcsource  in  2  from decode: 00 sequential, 01 branch (bpc), 10 register target (rpc), 11 jump (jpc).
- bpc  in  32  branch target.
- jpc  in  32  jump target.
- rpc  in  32  register-indirect target.
- id_stall  in  1  decode cannot accept a new instruction this cycle.
- imem_req  out  1  instruction memory request valid.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_ready  in  1  response valid and request accepted this cycle.
- imem_rdata  in  32  fetched instruction.
- id_pc4  out  32  PC+4 of the instruction held in IF/ID.
- id_inst  out  32  instruction held in IF/ID; NOP_INST when id_valid=0.
- id_valid  out  1  IF/ID holds a live instruction.

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, id_valid=0, id_inst=NOP_INST, id_pc4=RESET_PC+4, imem_req=0, kill=0.
- imem_req rises the first cycle after reset deassertion.
- Reset asserted mid-request discards the transaction. No memory response is consumed while clrn=1.
- Redirect: a redirect is pcsource!=00 with id_valid=1 and id_stall=0. Redirect is ignored when id_stall=1; decode holds pcsource until the stall releases.
- Redirect target: the 01/10/11 target is written to pc on that edge.
- On redirect, IF/ID loads NOP (id_valid=0) regardless of any response that cycle.
- State FETCH: imem_req=1, imem_addr=pc.
  - On imem_ready and no redirect and no kill: if id_stall=0, load IF/ID (inst=imem_rdata, pc4=pc+4, valid=1), set pc=pc+4, stay in FETCH. If id_stall=1, latch the response into the skid register, set pc=pc+4, go to HOLD.
  - On redirect while a request is outstanding with imem_ready=0: set kill=1 and stay in FETCH with imem_addr still at the old pc until the response arrives. The memory contract forbids changing an unaccepted address.
  - Response with kill=1 is dropped; kill clears; imem_addr moves to the latched redirect target (held in pc) the next cycle.
- State HOLD: imem_req=0. When id_stall=0, the skid entry moves into IF/ID and the state returns to FETCH.
- Stall on IF/ID: when id_stall=1, the IF/ID register is held unchanged.
- IF/ID with nothing new: when id_stall=0 and no response is available, id_valid=0 and id_inst=NOP_INST.
- Latency: in steady state with zero-wait memory (ready in the cycle the request is presented), one instruction per cycle; an instruction appears on id_* 1 cycle after imem_ready.
- Arithmetic: all PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0. Target bits [1:0] are forced to 0.
- Simultaneous imem_ready + redirect + id_stall=0: the redirect wins, the response is discarded, and pc takes the target.

Optional Feature:
- Macro: IF_PERF_EN.
- When defined, adds outputs perf_fetched[31:0] (count of instructions loaded into IF/ID with valid=1) and perf_squashed[31:0] (count of responses dropped by kill or redirect).
- Both counters reset to 0, saturate at 32'hFFFF_FFFF, and count only when clrn=0.
- When undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_REG=2'b10, PCSRC_JMP=2'b11.
  - IF state encoding FETCH/HOLD.
  - NOP_INST default.
- One sub-module, if_id_reg: the IF/ID register with hold (stall) and flush inputs.
- Next-PC mux and the FSM stay in the top module.

Test Plan:
- Reset then zero-wait memory, id_stall=0 -> imem_addr 0,4,8,...; id_valid=1 from cycle 2; id_pc4 = addr+4 each cycle.
- Fetch at pc=0x10 with id_stall=1 for 3 cycles -> inst at 0x10 held in HOLD; no new request; released on stall drop; next imem_addr=0x14.
- Branch redirect pcsource=01, bpc=0x100 with response ready same cycle -> that response dropped; id_valid=0 for one cycle; next imem_addr=0x100.
- Redirect to jpc=0x200 while request to 0x20 outstanding for 4 cycles -> imem_addr stays 0x20; response dropped; next request 0x200; perf_squashed=1 with IF_PERF_EN.
- pc=0xFFFF_FFFC sequential fetch -> next imem_addr=0x0000_0000.
- Assert clrn during a 3-cycle-wait fetch -> all outputs at reset values immediately (async); first request after release goes to RESET_PC.
